// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined MIPS core: word/register widths,
// ALU operation encodings, the portB source select and the ID/EX latch layout.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int AOP_W  = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // ALU operation encodings; ALU_SLL is 0 so an all-zero bubble is a harmless shift.
    typedef enum logic [AOP_W-1:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // portB source select; encoding 3 is reserved and behaves like RT.
    typedef enum logic [1:0] {
        RT    = 2'd0,
        IMM   = 2'd1,
        SHAMT = 2'd2
    } portb_sel_t;

    // Fields held in the ID/EX latch. idex_t'0 is the bubble.
    typedef struct packed {
        logic       valid;
        aluop_t     aluop;
        regbits_t   rs;
        regbits_t   rt;
        word_t      rdata1;
        word_t      rdata2;
        word_t      imm;
        logic [4:0] shamt;
        portb_sel_t bsel;
        logic       shift;
        regbits_t   wsel;
        logic       regwen;
        logic       memread;
    } idex_t;

    // True when a downstream stage will write the given nonzero source register.
    function automatic logic fwd_hit(input logic regwen, input regbits_t wsel,
                                     input regbits_t src);
        return regwen && (wsel == src) && (src != '0);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: picks the freshest value of the
// register among EX/MEM, MEM/WB and the value read from the register file.
module fwd_mux
    import cpu_types_pkg::*;
(
    input  regbits_t reg_num,
    input  word_t    latched_data,
    input  logic     exmem_regwen,
    input  regbits_t exmem_wsel,
    input  word_t    exmem_result,
    input  logic     memwb_regwen,
    input  regbits_t memwb_wsel,
    input  word_t    memwb_result,
    output word_t    fwd_data
);

    // EX/MEM is younger than MEM/WB, so it wins when both target the register.
    always_comb begin
        fwd_data = latched_data;
        if (fwd_hit(exmem_regwen, exmem_wsel, reg_num)) begin
            fwd_data = exmem_result;
        end else if (fwd_hit(memwb_regwen, memwb_wsel, reg_num)) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline latch plus operand selection for the execute ALU.
// Pipeline control: flush replaces the latched instruction with a bubble and
// takes priority over stall; stall holds every latched field; otherwise the
// decode fields are taken every cycle (in_valid = 0 latches a bubble that still
// carries the presented fields). Forwarding is purely combinational and keeps
// tracking the downstream stages while stalled.
module ex_operand_stage
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       stall,
    input  logic       flush,
    input  logic       in_valid,
    input  aluop_t     in_aluop,
    input  regbits_t   in_rs,
    input  regbits_t   in_rt,
    input  word_t      in_rdata1,
    input  word_t      in_rdata2,
    input  word_t      in_imm,
    input  logic [4:0] in_shamt,
    input  logic [1:0] in_bsel,
    input  logic       in_shift,
    input  regbits_t   in_wsel,
    input  logic       in_regwen,
    input  logic       in_memread,
    input  logic       exmem_regwen,
    input  logic       memwb_regwen,
    input  regbits_t   exmem_wsel,
    input  regbits_t   memwb_wsel,
    input  word_t      exmem_result,
    input  word_t      memwb_result,
    output logic       ex_valid,
    output word_t      portA,
    output word_t      portB,
    output aluop_t     aluop,
    output regbits_t   ex_wsel,
    output logic       ex_regwen,
    output logic       ex_memread,
    output logic       lu_hazard
);

    idex_t idex_q;
    idex_t idex_d;
    word_t rs_fwd;
    word_t rt_fwd;

    // Pack the decode fields into the latch layout.
    always_comb begin
        idex_d         = '0;
        idex_d.valid   = in_valid;
        idex_d.aluop   = in_aluop;
        idex_d.rs      = in_rs;
        idex_d.rt      = in_rt;
        idex_d.rdata1  = in_rdata1;
        idex_d.rdata2  = in_rdata2;
        idex_d.imm     = in_imm;
        idex_d.shamt   = in_shamt;
        idex_d.bsel    = portb_sel_t'(in_bsel);
        idex_d.shift   = in_shift;
        idex_d.wsel    = in_wsel;
        idex_d.regwen  = in_regwen;
        idex_d.memread = in_memread;
    end

    // ID/EX latch: flush beats stall, stall beats load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idex_q <= '0;
        end else if (flush) begin
            idex_q <= '0;
        end else if (!stall) begin
            idex_q <= idex_d;
        end
    end

    fwd_mux u_fwd_rs (
        .reg_num      (idex_q.rs),
        .latched_data (idex_q.rdata1),
        .exmem_regwen (exmem_regwen),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_result (memwb_result),
        .fwd_data     (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .reg_num      (idex_q.rt),
        .latched_data (idex_q.rdata2),
        .exmem_regwen (exmem_regwen),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_result (memwb_result),
        .fwd_data     (rt_fwd)
    );

    // ALU operand selection; shifts take the shifted value from rt on portA,
    // and the immediate is never forwarded.
    always_comb begin
        portA = idex_q.shift ? rt_fwd : rs_fwd;
        case (idex_q.bsel)
            RT:      portB = rt_fwd;
            IMM:     portB = idex_q.imm;
            SHAMT:   portB = {27'b0, idex_q.shamt};
            default: portB = rt_fwd;
        endcase
    end

    // Latched controls, gated so a bubble never writes or loads.
    always_comb begin
        ex_valid   = idex_q.valid;
        aluop      = idex_q.aluop;
        ex_wsel    = idex_q.wsel;
        ex_regwen  = idex_q.valid & idex_q.regwen;
        ex_memread = idex_q.valid & idex_q.memread;
    end

    // Load-use: the load in EX writes a register that decode wants to read now.
    always_comb begin
        lu_hazard = in_valid & ex_memread & (ex_wsel != '0) &
                    ((ex_wsel == in_rs) | (ex_wsel == in_rt));
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, latching, forwarding
// priority, shift/immediate muxing, load-use detection, stall/flush and async reset.
module tb_ex_operand_stage;
    import cpu_types_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic       stall, flush, in_valid;
    aluop_t     in_aluop;
    regbits_t   in_rs, in_rt, in_wsel;
    word_t      in_rdata1, in_rdata2, in_imm;
    logic [4:0] in_shamt;
    logic [1:0] in_bsel;
    logic       in_shift, in_regwen, in_memread;
    logic       exmem_regwen, memwb_regwen;
    regbits_t   exmem_wsel, memwb_wsel;
    word_t      exmem_result, memwb_result;
    logic       ex_valid, ex_regwen, ex_memread, lu_hazard;
    word_t      portA, portB;
    aluop_t     aluop;
    regbits_t   ex_wsel;

    int n_checks = 0;
    int n_fail   = 0;

    ex_operand_stage dut (
        .CLK(CLK), .nRST(nRST), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_aluop(in_aluop), .in_rs(in_rs), .in_rt(in_rt),
        .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_bsel(in_bsel), .in_shift(in_shift),
        .in_wsel(in_wsel), .in_regwen(in_regwen), .in_memread(in_memread),
        .exmem_regwen(exmem_regwen), .memwb_regwen(memwb_regwen),
        .exmem_wsel(exmem_wsel), .memwb_wsel(memwb_wsel),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .portA(portA), .portB(portB), .aluop(aluop),
        .ex_wsel(ex_wsel), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .lu_hazard(lu_hazard)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        stall = 0; flush = 0; in_valid = 0; in_aluop = ALU_SLL;
        in_rs = 0; in_rt = 0; in_rdata1 = 0; in_rdata2 = 0; in_imm = 0;
        in_shamt = 0; in_bsel = 0; in_shift = 0; in_wsel = 0;
        in_regwen = 0; in_memread = 0;
    endtask

    task automatic clear_fwd();
        exmem_regwen = 0; exmem_wsel = 0; exmem_result = 0;
        memwb_regwen = 0; memwb_wsel = 0; memwb_result = 0;
    endtask

    task automatic present(input aluop_t op, input regbits_t rs, input word_t d1,
                           input regbits_t rt, input word_t d2, input logic [1:0] bsel,
                           input regbits_t wsel, input logic regwen, input logic memread);
        in_valid = 1; in_aluop = op; in_rs = rs; in_rdata1 = d1; in_rt = rt;
        in_rdata2 = d2; in_bsel = bsel; in_wsel = wsel; in_regwen = regwen;
        in_memread = memread; in_shift = 0; in_shamt = 0; in_imm = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".ex_valid"},   32'(ex_valid),   0);
        check({tag, ".portA"},      portA,           0);
        check({tag, ".portB"},      portB,           0);
        check({tag, ".aluop"},      32'(aluop),      32'(ALU_SLL));
        check({tag, ".ex_wsel"},    32'(ex_wsel),    0);
        check({tag, ".ex_regwen"},  32'(ex_regwen),  0);
        check({tag, ".ex_memread"}, 32'(ex_memread), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        clear_fwd();

        // Reset then idle
        #3;
        check_zero_outputs("reset");
        check("reset.lu_hazard", 32'(lu_hazard), 0);
        #9 nRST = 1;
        step();
        check_zero_outputs("idle");

        // Basic load: ADD r1(5) + r2(7)
        present(ALU_ADD, 5'd1, 32'h5, 5'd2, 32'h7, 2'd0, 5'd4, 1'b1, 1'b0);
        step();
        check("basic.portA", portA, 32'h5);
        check("basic.portB", portB, 32'h7);
        check("basic.aluop", 32'(aluop), 32'(ALU_ADD));
        check("basic.ex_valid", 32'(ex_valid), 1);
        check("basic.ex_regwen", 32'(ex_regwen), 1);
        check("basic.ex_wsel", 32'(ex_wsel), 4);

        // Forwarding priority on rs = 3
        present(ALU_ADD, 5'd3, 32'h1111, 5'd5, 32'h2222, 2'd0, 5'd6, 1'b1, 1'b0);
        step();
        exmem_regwen = 1; exmem_wsel = 3; exmem_result = 32'hAAAA;
        memwb_regwen = 1; memwb_wsel = 3; memwb_result = 32'hBBBB;
        #1;
        check("fwd.exmem_prio", portA, 32'hAAAA);
        check("fwd.rt_unhit", portB, 32'h2222);
        exmem_regwen = 0; #1;
        check("fwd.memwb", portA, 32'hBBBB);
        memwb_wsel = 5; #1;
        check("fwd.rt_memwb", portB, 32'hBBBB);
        check("fwd.rs_latched", portA, 32'h1111);
        clear_fwd();
        present(ALU_ADD, 5'd0, 32'h1234, 5'd0, 32'h5678, 2'd0, 5'd6, 1'b1, 1'b0);
        step();
        exmem_regwen = 1; exmem_wsel = 0; exmem_result = 32'hAAAA;
        memwb_regwen = 1; memwb_wsel = 0; memwb_result = 32'hBBBB;
        #1;
        check("fwd.r0_rs", portA, 32'h1234);
        check("fwd.r0_rt", portB, 32'h5678);
        clear_fwd();

        // Shift: SLL rt=1 by shamt 4
        present(ALU_SLL, 5'd7, 32'h99, 5'd6, 32'h1, 2'd2, 5'd8, 1'b1, 1'b0);
        in_shift = 1; in_shamt = 5'd4;
        step();
        check("sll.portA", portA, 32'h1);
        check("sll.portB", portB, 32'h4);
        check("sll.aluop", 32'(aluop), 32'(ALU_SLL));

        // ADDI with negative immediate, rt forward must not leak into portB
        present(ALU_ADD, 5'd1, 32'hA, 5'd9, 32'h33, 2'd1, 5'd9, 1'b1, 1'b0);
        in_imm = 32'hFFFF_FFFC;
        step();
        exmem_regwen = 1; exmem_wsel = 9; exmem_result = 32'hDEAD;
        #1;
        check("addi.portB", portB, 32'hFFFF_FFFC);
        check("addi.portA", portA, 32'hA);
        clear_fwd();

        // Reserved bsel 3 behaves like rt (and forwards)
        present(ALU_OR, 5'd1, 32'hA, 5'd9, 32'h33, 2'd3, 5'd2, 1'b1, 1'b0);
        in_imm = 32'h0F0F;
        step();
        check("bsel3.latched", portB, 32'h33);
        exmem_regwen = 1; exmem_wsel = 9; exmem_result = 32'hDEAD;
        #1;
        check("bsel3.fwd", portB, 32'hDEAD);
        clear_fwd();

        // Load-use hazard
        present(ALU_ADD, 5'd1, 32'h100, 5'd0, 32'h0, 2'd1, 5'd8, 1'b1, 1'b1);
        step();
        check("lw.ex_memread", 32'(ex_memread), 1);
        present(ALU_ADD, 5'd2, 32'h1, 5'd8, 32'h2, 2'd0, 5'd3, 1'b1, 1'b0);
        #1;
        check("lu.rt_match", 32'(lu_hazard), 1);
        in_valid = 0; #1;
        check("lu.no_valid", 32'(lu_hazard), 0);
        in_valid = 1; in_rs = 5'd8; in_rt = 5'd4; #1;
        check("lu.rs_match", 32'(lu_hazard), 1);
        in_rs = 5'd2; in_rt = 5'd8;
        stall = 1; flush = 1;
        step();
        check("lu.flush_valid", 32'(ex_valid), 0);
        check("lu.flush_regwen", 32'(ex_regwen), 0);
        check("lu.flush_clear", 32'(lu_hazard), 0);
        stall = 0; flush = 0;
        step();
        check("lu.replay_portB", portB, 32'h2);
        check("lu.replay_valid", 32'(ex_valid), 1);
        present(ALU_ADD, 5'd1, 32'h100, 5'd0, 32'h0, 2'd1, 5'd0, 1'b1, 1'b1);
        step();
        present(ALU_ADD, 5'd0, 32'h1, 5'd0, 32'h2, 2'd0, 5'd3, 1'b1, 1'b0);
        #1;
        check("lu.wsel0", 32'(lu_hazard), 0);

        // in_valid = 0 without flush: fields latched, controls gated
        present(ALU_SUB, 5'd1, 32'h77, 5'd2, 32'h88, 2'd0, 5'd12, 1'b1, 1'b1);
        in_valid = 0;
        step();
        check("inv.ex_valid", 32'(ex_valid), 0);
        check("inv.ex_regwen", 32'(ex_regwen), 0);
        check("inv.ex_memread", 32'(ex_memread), 0);
        check("inv.ex_wsel", 32'(ex_wsel), 12);
        check("inv.portA", portA, 32'h77);

        // Stall holds fields for 3 cycles; forwarding still tracks
        present(ALU_AND, 5'd1, 32'h55, 5'd2, 32'h66, 2'd0, 5'd3, 1'b1, 1'b0);
        step();
        present(ALU_XOR, 5'd10, 32'h123, 5'd11, 32'h456, 2'd0, 5'd13, 1'b1, 1'b0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.portA", portA, 32'h55);
            check("stall.portB", portB, 32'h66);
            check("stall.ex_wsel", 32'(ex_wsel), 3);
            check("stall.aluop", 32'(aluop), 32'(ALU_AND));
        end
        exmem_regwen = 1; exmem_wsel = 1; exmem_result = 32'h77; #1;
        check("stall.fwd", portA, 32'h77);
        clear_fwd();
        stall = 0;
        step();
        check("unstall.portA", portA, 32'h123);
        check("unstall.aluop", 32'(aluop), 32'(ALU_XOR));

        // Flush alone
        flush = 1;
        step();
        check_zero_outputs("flush");
        flush = 0;

        // Async reset mid-cycle
        present(ALU_ADD, 5'd1, 32'hCAFE, 5'd2, 32'hBEEF, 2'd0, 5'd7, 1'b1, 1'b1);
        step();
        check("prerst.portA", portA, 32'hCAFE);
        #2 nRST = 0;
        #1;
        check_zero_outputs("async_rst");
        #3 nRST = 1;
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
